// File: rtl/fetch_pkg.sv
// Shared types and default constants for the fetch run-control sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam int PW_DEF = 11;
    localparam int CW_DEF = 16;

    // Default program start addresses, indexed by ProgSel.
    localparam int BASE0_DEF = 0;
    localparam int BASE1_DEF = 128;
    localparam int BASE2_DEF = 256;
    localparam int BASE3_DEF = 512;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear (dominant over enable) that sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         i_clear,
    input  logic         i_enable,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {W{1'b1}})) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Run-control FSM for the fetch unit: arms a program base, runs, stalls,
// resolves taken branches into PC loads, and acknowledges halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int            PW    = PW_DEF,
    parameter int            CW    = CW_DEF,
    parameter logic [PW-1:0] BASE0 = PW'(BASE0_DEF),
    parameter logic [PW-1:0] BASE1 = PW'(BASE1_DEF),
    parameter logic [PW-1:0] BASE2 = PW'(BASE2_DEF),
    parameter logic [PW-1:0] BASE3 = PW'(BASE3_DEF)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [1:0]    ProgSel,
    input  logic          Halt,
    input  logic          Branch,
    input  logic          AluZero,
    input  logic          Stall,
    input  logic [PW-1:0] Target,
    output logic          PcLoad,
    output logic          PcEn,
    output logic [PW-1:0] PcTarget,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_running;
    logic          r_done;
    logic [PW-1:0] w_base;

    always_comb begin
        case (ProgSel)
            2'd0:    w_base = BASE0;
            2'd1:    w_base = BASE1;
            2'd2:    w_base = BASE2;
            default: w_base = BASE3;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_running <= (w_next_state == ST_RUN);
            r_done    <= (w_next_state == ST_HALT);
        end
    end

    // NOTE: each comb block assigns defaults first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (Start)  w_next_state = ST_ARM;
            ST_ARM:  if (!Start) w_next_state = ST_RUN;
            ST_RUN: begin
                if (Start)               w_next_state = ST_ARM;
                else if (Stall)          w_next_state = ST_RUN;
                else if (Halt)           w_next_state = ST_HALT;
            end
            ST_HALT: if (Start)  w_next_state = ST_ARM;
            default:             w_next_state = ST_IDLE;
        endcase
    end

    // An abort from RUN drives ARM outputs in the same cycle it is seen.
    always_comb begin
        PcLoad   = 1'b0;
        PcEn     = 1'b0;
        PcTarget = Target;
        case (r_state)
            ST_ARM: begin
                PcLoad   = 1'b1;
                PcEn     = 1'b1;
                PcTarget = w_base;
            end
            ST_RUN: begin
                if (Start) begin
                    PcLoad   = 1'b1;
                    PcEn     = 1'b1;
                    PcTarget = w_base;
                end else if (Stall || Halt) begin
                    PcEn     = 1'b0;
                end else if (Branch && AluZero) begin
                    PcLoad   = 1'b1;
                    PcEn     = 1'b1;
                end else begin
                    PcEn     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Clearing on entry to ARM makes the count read zero the cycle after re-arm.
    sat_counter #(
        .W (CW)
    ) u_cycle_cnt (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_clear  (w_next_state == ST_ARM),
        .i_enable (r_state == ST_RUN),
        .o_count  (CycleCount)
    );

    assign Running = r_running;
    assign Done    = r_done;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer with hand-computed expectations.
module tb_fetch_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [1:0]  ProgSel;
    logic        Halt;
    logic        Branch;
    logic        AluZero;
    logic        Stall;
    logic [10:0] Target;
    logic        PcLoad;
    logic        PcEn;
    logic [10:0] PcTarget;
    logic        Running;
    logic        Done;
    logic [15:0] CycleCount;

    int n_compared   = 0;
    int n_mismatched = 0;

    fetch_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .ProgSel    (ProgSel),
        .Halt       (Halt),
        .Branch     (Branch),
        .AluZero    (AluZero),
        .Stall      (Stall),
        .Target     (Target),
        .PcLoad     (PcLoad),
        .PcEn       (PcEn),
        .PcTarget   (PcTarget),
        .Running    (Running),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 time unit after the edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; ProgSel = 2'd0; Halt = 1'b0;
        Branch = 1'b0; AluZero = 1'b0; Stall = 1'b0; Target = 11'd0;
        #12;
        check("rst_running", Running, 0);
        check("rst_done", Done, 0);
        check("rst_count", CycleCount, 0);
        check("rst_pcen", PcEn, 0);
        check("rst_pcload", PcLoad, 0);
        Reset = 1'b0;

        // Arm program 1 for three cycles, then release.
        tick();
        Start = 1'b1; ProgSel = 2'd1;
        tick(); settle();
        check("arm_pcload", PcLoad, 1);
        check("arm_pcen", PcEn, 1);
        check("arm_target", PcTarget, 128);
        check("arm_running", Running, 0);
        tick(); tick(); settle();
        check("arm_count", CycleCount, 0);
        Start = 1'b0;
        settle();
        check("arm_last_pcload", PcLoad, 1);
        check("arm_last_target", PcTarget, 128);
        tick(); settle();
        check("run_running", Running, 1);
        check("run_count0", CycleCount, 0);
        check("run_seq_pcen", PcEn, 1);
        check("run_seq_pcload", PcLoad, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(); settle();
            check($sformatf("run_count%0d", i), CycleCount, i);
        end

        // Taken, not-taken, and AluZero without a branch.
        Branch = 1'b1; AluZero = 1'b1; Target = 11'd300;
        settle();
        check("br_taken_pcload", PcLoad, 1);
        check("br_taken_pcen", PcEn, 1);
        check("br_taken_target", PcTarget, 300);
        AluZero = 1'b0;
        settle();
        check("br_not_pcload", PcLoad, 0);
        check("br_not_pcen", PcEn, 1);
        Branch = 1'b0; AluZero = 1'b1;
        settle();
        check("nobr_pcload", PcLoad, 0);
        AluZero = 1'b0;
        tick(); settle();
        check("run_count4", CycleCount, 4);

        // Stall dominates halt for two cycles, then halt is accepted.
        Stall = 1'b1; Halt = 1'b1;
        settle();
        check("stall_pcen", PcEn, 0);
        check("stall_pcload", PcLoad, 0);
        tick(); settle();
        check("stall1_running", Running, 1);
        check("stall1_count", CycleCount, 5);
        tick(); settle();
        check("stall2_running", Running, 1);
        check("stall2_done", Done, 0);
        check("stall2_count", CycleCount, 6);
        Stall = 1'b0;
        settle();
        check("halt_pcen", PcEn, 0);
        tick(); settle();
        check("halt_done", Done, 1);
        check("halt_running", Running, 0);
        check("halt_count", CycleCount, 7);
        Halt = 1'b0;
        tick(); settle();
        check("halt_frozen", CycleCount, 7);
        check("halt_done_hold", Done, 1);

        // Re-arm from HALT with program 3 via a one-cycle Start pulse.
        Start = 1'b1; ProgSel = 2'd3;
        settle();
        check("halt_start_pcload", PcLoad, 0);
        tick(); settle();
        Start = 1'b0;
        settle();
        check("rearm_done", Done, 0);
        check("rearm_target", PcTarget, 512);
        check("rearm_pcload", PcLoad, 1);
        check("rearm_count", CycleCount, 0);
        tick(); settle();
        check("rerun_running", Running, 1);
        tick(); settle();
        check("rerun_count1", CycleCount, 1);

        // Abort mid-RUN: ARM outputs in the same cycle.
        Start = 1'b1; ProgSel = 2'd2;
        settle();
        check("abort_pcload", PcLoad, 1);
        check("abort_pcen", PcEn, 1);
        check("abort_target", PcTarget, 256);
        tick(); settle();
        check("abort_running", Running, 0);
        check("abort_count", CycleCount, 0);
        Start = 1'b0;
        tick(); tick(); tick(); settle();
        check("abort_rerun_count", CycleCount, 2);

        // Asynchronous reset between edges.
        #2;
        Reset = 1'b1;
        #1;
        check("async_running", Running, 0);
        check("async_done", Done, 0);
        check("async_count", CycleCount, 0);
        check("async_pcen", PcEn, 0);
        check("async_pcload", PcLoad, 0);
        Reset = 1'b0;

        // Saturation: run program 0 long enough to reach all-ones.
        tick();
        Start = 1'b1; ProgSel = 2'd0;
        tick(); settle();
        check("sat_arm_target", PcTarget, 0);
        Start = 1'b0;
        tick();
        repeat (65535) @(posedge Clk);
        #2;
        check("sat_reach", CycleCount, 65535);
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check($sformatf("sat_hold%0d", i), CycleCount, 65535);
        end
        check("sat_running", Running, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Run-control FSM that sequences the instruction fetch unit: it arms a program at its base address, releases the PC to advance, resolves taken branches into a PC load, freezes on datapath stalls, and detects program halt. It sits between the top-level test harness (Start/Done handshake) and the fetch unit's PC register, and also reports a per-program cycle count for performance checks.

## Interface
- PW, 11, PC / target width
- CW, 16, cycle counter width
- BASE0, 11'd0, start address of program 0
- BASE1, 11'd128, start address of program 1
- BASE2, 11'd256, start address of program 2
- BASE3, 11'd512, start address of program 3
- Clk  in  1  clock, posedge
- Reset  in  1  asynchronous, active-high; forces IDLE
- Start  in  1  level; high = arm/hold next program, falling edge = begin run
- ProgSel  in  2  program select, sampled while armed
- Halt  in  1  decoder flag: current instruction is halt
- Branch  in  1  decoder flag: current instruction is conditional branch
- AluZero  in  1  ALU zero flag for current instruction
- Stall  in  1  datapath requests PC hold this cycle
- Target  in  PW  branch target from decode
- PcLoad  out  1  fetch unit loads PcTarget at next posedge
- PcEn  out  1  fetch unit advances PC (+1, or load if PcLoad) at next posedge
- PcTarget  out  PW  address to load
- Running  out  1  high in RUN
- Done  out  1  high in HALT (program finished ack)
- CycleCount  out  CW  cycles spent in RUN for current program

## Operation
- States: IDLE, ARM, RUN, HALT. Reset -> IDLE.
- IDLE: all control outputs 0. Start=1 -> ARM.
- ARM: PcLoad=1, PcEn=1, PcTarget=BASE[ProgSel] every cycle (last ProgSel before release wins); CycleCount cleared to 0. Start=0 -> RUN.
- RUN: Running=1. Priority per cycle: Start=1 (abort) > Stall > Halt > taken branch > sequential.
  - Start=1: -> ARM, behaves as ARM outputs that same cycle.
  - Stall=1: PcEn=0, PcLoad=0; Halt/Branch ignored this cycle; stay RUN.
  - Halt=1: PcEn=0, PcLoad=0; -> HALT.
  - Branch=1 and AluZero=1: PcEn=1, PcLoad=1, PcTarget=Target.
  - otherwise: PcEn=1, PcLoad=0 (PC+1).
- HALT: Done=1, PcEn=0, PcLoad=0, CycleCount frozen. Start=1 -> ARM (Done drops on that transition).
- PcTarget = Target whenever not in ARM (value only meaningful with PcLoad).
- CycleCount increments by 1 on every posedge while in RUN, including stall cycles and the halt cycle; saturates at 2^CW-1, no wrap.
- Branch with AluZero=0 is not taken; AluZero ignored when Branch=0.

## Timing
- State, Done, Running, CycleCount are registered; reset values: state IDLE, Done 0, Running 0, CycleCount 0.
- PcLoad, PcEn, PcTarget are combinational from state and current-cycle inputs; fetch unit acts on them at the next posedge (PC update latency 1 cycle).
- First RUN cycle: PC already equals BASE[ProgSel] (loaded during final ARM cycle).
- Done asserts the cycle after Halt is accepted; deasserts the cycle after Start rises.
- Reset asserted mid-RUN: outputs go to reset values immediately (async), no PC load issued.
- Start high for one cycle in HALT is sufficient to re-arm.

## Structure
- Package fetch_pkg: state enum (IDLE, ARM, RUN, HALT), PW/CW constants, default BASE0..BASE3 table.
- One sub-module: sat_counter (CW-bit, sync clear, enable, saturate) for CycleCount.
- Base-address mux and output decode stay inline in fetch_sequencer.

## Test plan
- Reset, Start=1 ProgSel=1 for 3 cycles, Start=0 -> PcLoad=1 PcTarget=128 during ARM; RUN entered, Running=1, CycleCount 0 then 1,2,3 on successive edges.
- In RUN, Branch=1 AluZero=1 Target=300 -> PcLoad=1 PcEn=1 PcTarget=300 that cycle; Branch=1 AluZero=0 -> PcLoad=0 PcEn=1.
- Stall=1 for 2 cycles with Halt=1 -> PcEn=0, state stays RUN, CycleCount still +2; Stall=0 Halt=1 -> Done=1 next cycle, CycleCount frozen.
- From HALT, Start=1 with ProgSel=3 -> Done=0 next cycle, PcTarget=512, CycleCount=0.
- Start=1 mid-RUN -> immediate ARM outputs (PcLoad=1, PcTarget=BASE[ProgSel]), Running=0 next cycle.
- Reset pulsed mid-RUN between edges -> Running=0, Done=0, CycleCount=0 without waiting for Clk; CycleCount forced to 2^16-1 stays saturated over 3 more RUN cycles.
